// File: rtl/line_clear_engine.sv
// Board line-clear engine: scans the board RAM bottom-up for full rows and, once granted,
// compacts the surviving rows downward and zero-fills the top. Define LINE_CLEAR_TOTAL_EN for the total_lines accumulator.
module line_clear_engine #(
    parameter int ROWS = 20,
    parameter int COLS = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            scan_start,
    input  logic            lineBreakMode,
    input  logic [COLS-1:0] row_rdata,
    output logic [4:0]      row_addr,
    output logic [COLS-1:0] row_wdata,
    output logic            row_we,
    output logic            lineBreak,
    output logic            busy,
    output logic            done,
    output logic [4:0]      lines_cleared,
    output logic [15:0]     total_lines
);

    typedef enum logic [2:0] {
        IDLE, SCAN_RD, SCAN_CHK, WAIT_LB, COL_RD, COL_CHK, FILL, DONE
    } state_t;

    localparam logic [5:0] LAST = 6'(ROWS - 1);

    state_t     state_q, state_d;
    logic [5:0] src_q, src_d;
    logic [5:0] dst_q, dst_d;
    logic       found_q, found_d;
    logic [4:0] lines_q, lines_d;
    logic       row_full;

    assign row_full = &row_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            found_q <= 1'b0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            found_q <= found_d;
            lines_q <= lines_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        found_d = found_q;
        lines_d = lines_q;
        case (state_q)
            IDLE: begin
                if (scan_start) begin
                    src_d   = LAST;
                    dst_d   = LAST;
                    found_d = 1'b0;
                    lines_d = '0;
                    state_d = SCAN_RD;
                end
            end
            SCAN_RD: state_d = SCAN_CHK;
            SCAN_CHK: begin
                if (row_full) found_d = 1'b1;
                if (src_q != 6'd0) begin
                    src_d   = src_q - 6'd1;
                    state_d = SCAN_RD;
                end else if (found_q || row_full) begin
                    src_d   = LAST;
                    state_d = WAIT_LB;
                end else begin
                    state_d = DONE;
                end
            end
            WAIT_LB: if (lineBreakMode) state_d = COL_RD;
            COL_RD:  state_d = COL_CHK;
            COL_CHK: begin
                // Full rows are skipped before dst moves, so dst never drops below src.
                if (row_full) lines_d = lines_q + 5'd1;
                else          dst_d   = dst_q - 6'd1;
                if (src_q != 6'd0) begin
                    src_d   = src_q - 6'd1;
                    state_d = COL_RD;
                end else if (dst_d[5]) begin
                    state_d = DONE;
                end else begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (dst_q == 6'd0) state_d = DONE;
                else               dst_d   = dst_q - 6'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row_addr  = '0;
        row_wdata = '0;
        row_we    = 1'b0;
        case (state_q)
            SCAN_RD, COL_RD: row_addr = src_q[4:0];
            COL_CHK: begin
                if (!row_full) begin
                    row_we    = 1'b1;
                    row_addr  = dst_q[4:0];
                    row_wdata = row_rdata;
                end
            end
            FILL: begin
                row_we   = 1'b1;
                row_addr = dst_q[4:0];
            end
            default: ;
        endcase
    end

    assign lineBreak     = (state_q == WAIT_LB);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign lines_cleared = lines_q;

`ifdef LINE_CLEAR_TOTAL_EN
    logic [15:0] total_lines_q, total_lines_d;
    logic [16:0] total_sum;

    always_comb begin
        total_sum     = {1'b0, total_lines_q} + 17'(lines_q);
        total_lines_d = total_lines_q;
        if (state_q == DONE)
            total_lines_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) total_lines_q <= '0;
        else       total_lines_q <= total_lines_d;
    end

    assign total_lines = total_lines_q;
`else
    assign total_lines = 16'h0000;
`endif

endmodule

// File: tb/tb_line_clear_engine.sv
// Randomized bench for line_clear_engine: a board RAM model plus a queue-based compaction
// reference; covers empty, single, multi, all-full clears, delayed grant and reset abort.
module tb_line_clear_engine;
    localparam int R = 20;
    localparam int C = 10;
    localparam logic [C-1:0] FULL = '1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         scan_start = 1'b0;
    logic         lineBreakMode = 1'b0;
    logic [C-1:0] row_rdata;
    logic [4:0]   row_addr;
    logic [C-1:0] row_wdata;
    logic         row_we, lineBreak, busy, done;
    logic [4:0]   lines_cleared;
    logic [15:0]  total_lines;

    line_clear_engine #(.ROWS(R), .COLS(C)) dut (
        .clk(clk), .reset(reset), .scan_start(scan_start), .lineBreakMode(lineBreakMode),
        .row_rdata(row_rdata), .row_addr(row_addr), .row_wdata(row_wdata), .row_we(row_we),
        .lineBreak(lineBreak), .busy(busy), .done(done), .lines_cleared(lines_cleared),
        .total_lines(total_lines)
    );

    always #5 clk = ~clk;

    // Board RAM with a side load port for presetting boards while the engine is idle.
    logic [C-1:0] mem [0:31];
    logic         ld_we = 1'b0;
    logic [4:0]   ld_addr = '0;
    logic [C-1:0] ld_data = '0;
    always @(posedge clk) begin
        if (ld_we)       mem[ld_addr] <= ld_data;
        else if (row_we) mem[row_addr] <= row_wdata;
        row_rdata <= mem[row_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [C-1:0] brd [R];
    logic [C-1:0] expb [R];
    int tot_mdl = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_board();
        for (int r = 0; r < R; r++) begin
            @(negedge clk);
            ld_we = 1'b1; ld_addr = 5'(r); ld_data = brd[r];
        end
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    // Reference: surviving rows keep their bottom-up order and settle at the bottom.
    task automatic model(output int lines);
        logic [C-1:0] kept [$];
        lines = 0;
        for (int r = R - 1; r >= 0; r--) begin
            if (brd[r] == FULL) lines++;
            else kept.push_back(brd[r]);
        end
        for (int r = 0; r < R; r++) begin
            if (lines == 0)                     expb[r] = brd[r];
            else if (R - 1 - r < kept.size())   expb[r] = kept[R - 1 - r];
            else                                expb[r] = '0;
        end
    endtask

    task automatic run_case(input string name, input int delay);
        int lines, cyc, nwr, lb_cyc, lb_first, lb_last, done_cyc, row_bad;
        bit to;
        load_board();
        model(lines);
        cyc = 0; nwr = 0; lb_cyc = 0; lb_first = 0; lb_last = 0; done_cyc = -1; to = 0;
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        while (1) begin
            cyc++;
            if (row_we) nwr++;
            if (lineBreak) begin
                lb_cyc++;
                if (lb_first == 0) lb_first = cyc;
                lb_last = cyc;
                lineBreakMode = (lb_cyc > delay);
            end else begin
                lineBreakMode = 1'($urandom % 2);
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            scan_start = busy && ($urandom % 4 == 0);
            if (cyc > 2000) begin
                to = 1;
                break;
            end
            @(negedge clk);
        end
        scan_start = 1'b0;
        lineBreakMode = 1'b0;
        chk({name, " timeout"}, 32'(to), 32'd0);
        if (lines > 0) begin
            chk({name, " done_cycle"}, done_cyc, 4 * R + delay + lines + 2);
            chk({name, " writes"}, nwr, R);
            chk({name, " lb_cycles"}, lb_cyc, delay + 1);
            chk({name, " lb_held"}, lb_last - lb_first + 1, delay + 1);
        end else begin
            chk({name, " done_cycle"}, done_cyc, 2 * R + 1);
            chk({name, " writes"}, nwr, 0);
            chk({name, " lb_cycles"}, lb_cyc, 0);
        end
        @(negedge clk);
        chk({name, " lines_cleared"}, 32'(lines_cleared), lines);
        chk({name, " busy_after"}, 32'(busy), 32'd0);
`ifdef LINE_CLEAR_TOTAL_EN
        tot_mdl = (tot_mdl + lines > 65535) ? 65535 : tot_mdl + lines;
`endif
        chk({name, " total_lines"}, 32'(total_lines), tot_mdl);
        row_bad = 0;
        for (int r = 0; r < R; r++) begin
            if (mem[r] !== expb[r]) begin
                row_bad++;
                $display("FAIL %s row%0d: got %0h expected %0h", name, r, mem[r], expb[r]);
            end
        end
        chk({name, " board_rows_bad"}, row_bad, 0);
    endtask

    task automatic outs_zero(input string name);
        chk({name, " row_we"}, 32'(row_we), 0);
        chk({name, " row_addr"}, 32'(row_addr), 0);
        chk({name, " row_wdata"}, 32'(row_wdata), 0);
        chk({name, " lineBreak"}, 32'(lineBreak), 0);
        chk({name, " busy"}, 32'(busy), 0);
        chk({name, " done"}, 32'(done), 0);
        chk({name, " lines_cleared"}, 32'(lines_cleared), 0);
        chk({name, " total_lines"}, 32'(total_lines), 0);
    endtask

    task automatic reset_abort();
        int k, bad;
        bit seen_lb, hit;
        for (int r = 0; r < R; r++) brd[r] = C'($urandom % (2 ** C - 1));
        brd[0] = FULL;
        load_board();
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        k = 0; seen_lb = 0; hit = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (lineBreak) begin
                seen_lb = 1;
                lineBreakMode = 1'b1;
            end else if (seen_lb) begin
                lineBreakMode = 1'b0;
                k++;
                if (k == 6) begin
                    chk("rst third COL_CHK writes", 32'(row_we), 1);
                    chk("rst third COL_CHK addr", 32'(row_addr), 17);
                    reset = 1'b1;
                    hit = 1;
                    break;
                end
            end
            @(negedge clk);
        end
        chk("rst reached COL_CHK", 32'(hit), 1);
        @(negedge clk);
        outs_zero("rst abort");
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (row_we || busy) bad++;
        end
        chk("rst stays idle", bad, 0);
        tot_mdl = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        outs_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int r = 0; r < R; r++) brd[r] = '0;
        run_case("empty", 0);

        for (int r = 0; r < R; r++) brd[r] = C'(r * 37 + 5);
        brd[19] = FULL;
        run_case("row19", 3);

        for (int r = 0; r < R; r++) brd[r] = C'(r * 53 + 11);
        brd[19] = FULL; brd[17] = FULL; brd[16] = FULL;
`ifdef LINE_CLEAR_TOTAL_EN
        @(negedge clk);
        force dut.total_lines_q = 16'hFFFE;
        @(negedge clk);
        release dut.total_lines_q;
        tot_mdl = 32'hFFFE;
`endif
        run_case("three_rows", 100);

        for (int r = 0; r < R; r++) brd[r] = FULL;
        run_case("all_full", 2);

        reset_abort();

        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r < R; r++)
                brd[r] = ($urandom % 4 == 0) ? FULL : C'($urandom % (2 ** C - 1));
            run_case($sformatf("rand%0d", t), int'($urandom_range(0, 5)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/line_clear_engine.md
LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

Interface
REQ-001 The module SHALL have the parameter ROWS, default 20, giving the number of board rows (row 0 = top, ROWS-1 = bottom).
REQ-002 The module SHALL have the parameter COLS, default 10, giving the number of cells per row; a row is full when all COLS bits are 1.
REQ-003 The port clk SHALL be an input, 1 bit wide: the single system clock.
REQ-004 The port reset SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 The port scan_start SHALL be an input, 1 bit wide: a one-cycle pulse after a piece locks, requesting a board scan.
REQ-006 The port lineBreakMode SHALL be an input, 1 bit wide: the game FSM grant; when it is high, collapse begins.
REQ-007 The port row_rdata SHALL be an input, COLS bits wide: board RAM read data, valid one cycle after row_addr.
REQ-008 The port row_addr SHALL be an output, 5 bits wide: board RAM row address.
REQ-009 The port row_wdata SHALL be an output, COLS bits wide: board RAM write data.
REQ-010 The port row_we SHALL be an output, 1 bit wide: board RAM write enable; it writes row_wdata to row_addr at the clock edge.
REQ-011 The port lineBreak SHALL be an output, 1 bit wide: a level signal meaning at least one full row was found and a grant is awaited.
REQ-012 The port busy SHALL be an output, 1 bit wide: high in every state except IDLE.
REQ-013 The port done SHALL be an output, 1 bit wide: a one-cycle pulse when the scan or collapse is complete.
REQ-014 The port lines_cleared SHALL be an output, 5 bits wide: the number of rows removed by the last operation, held until the next scan_start.
REQ-015 The port total_lines SHALL be an output, 16 bits wide: the cumulative count of cleared rows (see Configuration).

Function
REQ-016 The FSM SHALL have the states IDLE, SCAN_RD, SCAN_CHK, WAIT_LB, COL_RD, COL_CHK, FILL and DONE.
REQ-017 In IDLE, a scan_start pulse SHALL load the pointers src=dst=ROWS-1, clear the found flag and clear lines_cleared, then enter SCAN_RD.
REQ-018 SCAN_RD SHALL drive row_addr=src; SCAN_CHK SHALL sample row_rdata and set found if the row is full.
REQ-019 In SCAN_CHK, if src>0 the FSM SHALL decrement src and return to SCAN_RD; a full scan takes exactly 2*ROWS cycles.
REQ-020 At the end of the scan, if found=0 the FSM SHALL go to DONE and SHALL NOT issue any write.
REQ-021 At the end of the scan, if found=1 the FSM SHALL reset src to ROWS-1 and go to WAIT_LB.
REQ-022 In WAIT_LB, lineBreak SHALL be 1, and the FSM SHALL stay there indefinitely until lineBreakMode=1 is sampled, then go to COL_RD.
REQ-023 COL_RD SHALL drive row_addr=src. COL_CHK SHALL act on the sampled row as follows:
 - full row: increment lines_cleared, issue no write;
 - non-full row: assert row_we with row_addr=dst and row_wdata=row_rdata, then decrement dst.
REQ-024 After COL_CHK, if src>0 the FSM SHALL decrement src and go to COL_RD; otherwise it SHALL go to FILL.
REQ-025 FILL SHALL write zeros to rows dst down to 0, one row per cycle, then go to DONE; FILL SHALL take zero cycles if every row was kept, i.e. dst underflowed.
REQ-026 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-027 row_we SHALL be 0 in every state except COL_CHK (non-full row) and FILL.
REQ-028 scan_start SHALL be ignored while busy=1.
REQ-029 lineBreakMode SHALL be ignored outside WAIT_LB.
REQ-030 When the full row and dst are at the same position in COL_CHK, skip-then-write ordering SHALL hold, so no row is ever read after being overwritten (dst >= src is invariant).
REQ-031 All ROWS rows full SHALL produce lines_cleared=ROWS and ROWS zero-writes in FILL.
REQ-032 Pointers SHALL be 6 bits wide internally so that the dst underflow to -1 is detectable; row_addr SHALL be the low 5 bits.

Reset
REQ-033 When reset=1 at a clock edge, the FSM SHALL go to IDLE.
REQ-034 Reset SHALL clear all outputs: row_addr=0, row_wdata=0, row_we=0, lineBreak=0, busy=0, done=0, lines_cleared=0 and total_lines=0.
REQ-035 Reset during collapse SHALL abort immediately with no further writes; the board contents are then undefined and are reinitialised by the game reset.

Configuration
REQ-036 With the macro LINE_CLEAR_TOTAL_EN defined, total_lines SHALL add lines_cleared in the DONE cycle and saturate at 16'hFFFF.
REQ-037 Without LINE_CLEAR_TOTAL_EN, total_lines SHALL be tied to 16'h0000 and no accumulator logic SHALL be present.

Verification
REQ-038 Empty board with scan_start: the bench SHALL check that lineBreak stays 0, done pulses 40 cycles later, lines_cleared=0 and there are no writes.
REQ-039 Row 19 full, rows 0-18 holding distinct patterns, grant given: the bench SHALL check lines_cleared=1, that rows 1-19 equal the old rows 0-18, and that row 0 is all zeros.
REQ-040 Rows 19, 17 and 16 full, grant delayed 100 cycles: the bench SHALL check that lineBreak is held for the whole wait, that lines_cleared=3 and that the surviving rows are compacted in order.
REQ-041 All 20 rows full: the bench SHALL check lines_cleared=20, 20 FILL writes and a board of all zeros.
REQ-042 Reset asserted in the third COL_CHK cycle: the bench SHALL check that row_we=0 from the next cycle on and that the FSM is in IDLE with all outputs zero.
REQ-043 With LINE_CLEAR_TOTAL_EN and total_lines preset to 16'hFFFE, a 3-row clear SHALL give total_lines=16'hFFFF; scan_start while busy SHALL have no effect.
